// File: rtl/truth_table_pkg.sv
// Shared types and sizing for the truth-table sweeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  localparam int NUM_COMBOS = 8;
  localparam int COMBO_W    = 3;

  // Final input combination of a sweep; capturing it ends the sweep.
  localparam logic [COMBO_W-1:0] LAST_COMBO = COMBO_W'(NUM_COMBOS - 1);

endpackage

// File: rtl/dwell_timer.sv
// Hold counter: counts cycles spent on the current input combination.
// Latency: expire is combinational from the registered count (count==DWELL-1 while enabled).
// Backpressure: none; clear overrides enable and returns the count to 0.
module dwell_timer #(
  parameter int DWELL = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int                CNT_W    = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Expire on the last cycle of the hold; the count wraps to 0 on that same edge.
  assign expire = enable && (count_q == LAST_CNT);

  // Next count: clear wins, wrap on expire, otherwise step while enabled.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (expire) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives {a,b,c} through 0..7 and captures x/y into two 8-bit truth tables.
// Latency: 8*DWELL cycles of busy after the start edge, then a one-cycle done pulse.
// Backpressure: start is only honoured in IDLE; starts during RUN/DONE are dropped.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int DWELL = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       x,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_x,
  output logic [7:0] table_y
);

  sweep_state_t              state_q;
  sweep_state_t              state_d;
  logic [COMBO_W-1:0]        combo_q;
  logic [COMBO_W-1:0]        combo_d;
  logic [NUM_COMBOS-1:0]     table_x_q;
  logic [NUM_COMBOS-1:0]     table_x_d;
  logic [NUM_COMBOS-1:0]     table_y_q;
  logic [NUM_COMBOS-1:0]     table_y_d;
  logic                      busy_q;
  logic                      busy_d;
  logic                      done_q;
  logic                      done_d;

  logic                      timer_clear;
  logic                      timer_enable;
  logic                      timer_expire;

  // The hold counter only runs during a sweep and sits at 0 otherwise,
  // so every sweep starts its first hold from a clean count.
  assign timer_enable = (state_q == RUN);
  assign timer_clear  = (state_q != RUN);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_d   = state_q;
    combo_d   = combo_q;
    table_x_d = table_x_q;
    table_y_d = table_y_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          combo_d   = '0;
          table_x_d = '0;
          table_y_d = '0;
          busy_d    = 1'b1;
        end
      end

      RUN: begin
        busy_d = 1'b1;
        if (timer_expire) begin
          // x/y have been driven by combo_q for DWELL cycles; sample them now.
          table_x_d[combo_q] = x;
          table_y_d[combo_q] = y;
          if (combo_q == LAST_COMBO) begin
            // Park the inputs back at 000 rather than letting combo wrap.
            state_d = DONE;
            combo_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            combo_d = combo_q + COMBO_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        combo_d = '0;
      end
    endcase
  end

  // Sequencer state, stimulus and capture registers; every output comes from here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      combo_q   <= '0;
      table_x_q <= '0;
      table_y_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      combo_q   <= combo_d;
      table_x_q <= table_x_d;
      table_y_q <= table_y_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // combo_q is 0 outside RUN, so the inputs read 000 in IDLE and DONE.
  assign a       = combo_q[2];
  assign b       = combo_q[1];
  assign c       = combo_q[0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign table_x = table_x_q;
  assign table_y = table_y_q;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage for the 3-input/2-output combinational lab blocks. Drives `a`, `b`, `c` through all eight combinations in ascending order, holding each for a programmable number of cycles. Samples the block's `x`, `y` outputs at the end of each hold and assembles two 8-bit truth tables. It sits directly in front of the combinational block, feeding its inputs, and directly behind it, consuming its outputs. This replaces hand-written `#10` stimulus with synthesizable hardware.

## Interface
Parameters:
- `DWELL`, default 10, number of clock cycles each combination is held. Legal range 1..65535; the hold counter is `$clog2(DWELL+1)` bits wide.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  single-cycle request to begin a sweep.
- `a`  out  1  combination bit 2 (MSB).
- `b`  out  1  combination bit 1.
- `c`  out  1  combination bit 0 (LSB).
- `x`  in  1  block output under test.
- `y`  in  1  block output under test.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse when both tables are complete.
- `table_x`  out  8  bit i = `x` captured while `{a,b,c}` == i.
- `table_y`  out  8  bit i = `y` captured while `{a,b,c}` == i.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `busy`=0 and `{a,b,c}`=000.
  - On `start`=1, go to RUN, set combo=0 and hold count=0, and clear `table_x`/`table_y` to 0.
- RUN:
  - `busy`=1 and `{a,b,c}`=combo.
  - Hold count increments every cycle.
  - When count==DWELL-1:
    - Write `x` into `table_x[combo]` and `y` into `table_y[combo]`.
    - Reset count to 0.
    - If combo==7, go to DONE; otherwise combo+1.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then IDLE unconditionally.
- Tables hold their value after DONE until the next accepted `start`.
- `start` in RUN or DONE is ignored; it is not queued.
- combo never wraps: the 7→0 transition does not occur inside a sweep.
- Combinational `x`/`y` are sampled as-is. The DUT must settle within DWELL cycles; with DWELL=1 the sample is taken one cycle after the inputs change.

## Timing
- Reset (async, `rst_n`=0): state IDLE; `a`=`b`=`c`=0, `busy`=0, `done`=0, `table_x`=`table_y`=8'h00, and all counters are 0.
- Reset while in RUN or DONE aborts the sweep immediately; there is no `done` pulse.
- Edge E0, the edge that samples `start`=1: `busy` and `{a,b,c}`=000 appear after E0.
- Capture k (k=0..7) occurs at edge E0+(k+1)·DWELL. `{a,b,c}` changes to k+1 at the same edge.
- After edge E0+8·DWELL: `done`=1 and `busy`=0 for one cycle.
- `busy` is high for exactly 8·DWELL cycles.
- Start-to-start minimum spacing is 8·DWELL+2 cycles. A `start` in the cycle after `done` is accepted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `truth_table_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} sweep_state_t;`
  - `localparam int NUM_COMBOS = 8;`
  - `localparam int COMBO_W = 3;`
- Sub-module `dwell_timer`:
  - Parameterized by DWELL.
  - Inputs `clk`, `rst_n`, `clear`, `enable`.
  - Output `expire`, asserted when count==DWELL-1 and enable is high.
- The top holds the FSM, the combo register and the capture registers.

## Test plan
All scenarios use a behavioural DUT with x=a^b^c and y=majority(a,b,c).
- DWELL=10, pulse `start` once:
  - `{a,b,c}` steps 0..7, each held 10 cycles.
  - `busy` is high for 80 cycles and `done` pulses at cycle 81.
  - `table_x`=8'h96, `table_y`=8'hE8.
- DWELL=1:
  - `busy` is high for 8 cycles.
  - Tables are 8'h96/8'hE8, confirming the single-cycle-settle boundary.
- `start` held high for the entire sweep:
  - Exactly one sweep runs, with one `done` pulse.
  - A new sweep begins on the cycle after `done`, and the tables clear to 0 at that edge.
- Sweep of DWELL=10 with `rst_n` pulled low at cycle 35:
  - All outputs go to 0 immediately, with no `done`.
  - After release plus `start`, a full sweep completes correctly.
- DUT replaced by the constant x=1, y=0:
  - `table_x`=8'hFF, `table_y`=8'h00.
  - Then swap the DUT to the XOR/majority model, start again, and confirm the tables read 8'h96/8'hE8. This shows the clear on the new `start` works.
